// File: rtl/freq_meter_if.sv
// Measurement bus for freq_meter: enable and signal under test in,
// published count, overflow flag and status out.
interface freq_meter_if #(
   parameter int CNT_W = 26
);
   logic             en;
   logic             sig_in;
   logic [CNT_W-1:0] result;
   logic             result_valid;
   logic             ovf;
   logic             busy;

   modport master (
      output en, sig_in,
      input  result, result_valid, ovf, busy
   );

   modport slave (
      input  en, sig_in,
      output result, result_valid, ovf, busy
   );
endinterface

// File: rtl/freq_meter.sv
// Gated rising-edge counter: counts sig_in edges over GATE_CYCLES clocks and
// publishes the saturated count with a one-cycle strobe, back to back.
module freq_meter #(
   parameter int GATE_CYCLES = 50000000,
   parameter int CNT_W       = 26
) (
   input logic          clk50M,
   input logic          rst,
   freq_meter_if.slave  bus
);
   localparam int GW_RAW = $clog2(GATE_CYCLES);
   // FLUSH reuses the gate counter for 0..2, so it needs at least 2 bits
   localparam int GW = (GW_RAW < 2) ? 2 : GW_RAW;
   localparam logic [GW-1:0]    GATE_LAST  = GW'(GATE_CYCLES - 1);
   localparam logic [GW-1:0]    FLUSH_LAST = GW'(2);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic [1:0] {IDLE, FLUSH, GATE} state_t;

   state_t           state;
   logic             s1, s2, s3;
   logic             sig_rise;
   logic             at_max;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic             win_ovf;
   logic [CNT_W-1:0] result_r;
   logic             valid_r;
   logic             ovf_r;
   logic             busy_r;

   always_ff @(posedge clk50M) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sig_rise = s2 & ~s3;
   assign at_max   = (edge_cnt == CNT_MAX);

   always_ff @(posedge clk50M) begin
      if (rst) begin
         state    <= IDLE;
         gate_cnt <= '0;
         edge_cnt <= '0;
         win_ovf  <= 1'b0;
         result_r <= '0;
         valid_r  <= 1'b0;
         ovf_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         unique case (state)
            IDLE: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               win_ovf  <= 1'b0;
               if (bus.en) begin
                  state  <= FLUSH;
                  busy_r <= 1'b1;
               end
            end
            FLUSH: begin
               if (!bus.en) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else if (gate_cnt == FLUSH_LAST) begin
                  state    <= GATE;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  win_ovf  <= 1'b0;
               end else begin
                  gate_cnt <= gate_cnt + GW'(1);
               end
            end
            GATE: begin
               if (!bus.en) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else if (gate_cnt == GATE_LAST) begin
                  // last gate cycle still folds in its own edge before publishing
                  result_r <= (sig_rise && at_max) ? CNT_MAX : edge_cnt + CNT_W'(sig_rise);
                  ovf_r    <= win_ovf | (sig_rise & at_max);
                  valid_r  <= 1'b1;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  win_ovf  <= 1'b0;
               end else begin
                  gate_cnt <= gate_cnt + GW'(1);
                  if (sig_rise) begin
                     if (at_max) win_ovf  <= 1'b1;
                     else        edge_cnt <= edge_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.result       = result_r;
   assign bus.result_valid = valid_r;
   assign bus.ovf          = ovf_r;
   assign bus.busy         = busy_r;
endmodule
